// File: rtl/pq_client_arb_pkg.sv
// Shared priority-queue types plus arbiter state and operation encodings.
package pq_client_arb_pkg;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic OP_ENQ = 1'b0;
  localparam logic OP_DEQ = 1'b1;

endpackage

// File: rtl/pq_client_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned GW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic            valid,
  output logic [GW-1:0]   idx
);

  // Walk offsets from far to near so the nearest requester overwrites the result.
  always_comb begin
    int unsigned j;
    logic [GW-1:0] cand;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    cand  = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      j = 32'(ptr) + 32'(i);
      if (j >= NREQ) j = j - NREQ;
      cand = GW'(j);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pq_client_arb.sv
// Round-robin client arbiter sharing one priority queue among NREQ requesters.
module pq_client_arb
  import pq_client_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned GW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  kv_t  [NREQ-1:0]      kv_in,
  output logic [NREQ-1:0]      ack,
  output logic                 rsp_ok,
  output kv_t                  rsp_kv,
  output logic [GW-1:0]        gnt_id,
  output logic                 pq_rst,
  output logic                 pq_enq,
  output logic                 pq_deq,
  output kv_t                  pq_kvi,
  input  logic                 pq_full,
  input  logic                 pq_busy,
  input  logic                 pq_empty,
  input  kv_t                  pq_kvo
);

  arb_state_t    state, next_state;
  logic [GW-1:0] ptr;
  logic [GW-1:0] gnt;
  logic          op_q;
  kv_t           kv_q;
  logic          pick_valid;
  logic [GW-1:0] pick_idx;

  assign pq_rst = rst;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Strobes are decoded in ISSUE so full/empty are sampled in that same cycle.
  always_comb begin
    next_state = state;
    pq_enq     = 1'b0;
    pq_deq     = 1'b0;
    case (state)
      IDLE:  if (pick_valid && !pq_busy) next_state = ISSUE;
      ISSUE: begin
        if (op_q == OP_ENQ && !pq_full) begin
          pq_enq     = 1'b1;
          next_state = WAIT;
        end else if (op_q == OP_DEQ && !pq_empty) begin
          pq_deq     = 1'b1;
          next_state = WAIT;
        end else begin
          next_state = ACK;
        end
      end
      WAIT:  if (!pq_busy) next_state = ACK;
      ACK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Transaction latches and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      gnt    <= '0;
      op_q   <= OP_ENQ;
      kv_q   <= '0;
      pq_kvi <= '0;
      ack    <= '0;
      rsp_ok <= 1'b0;
      rsp_kv <= '0;
      gnt_id <= '0;
    end else begin
      ack <= '0;
      if (state == IDLE && next_state == ISSUE) begin
        gnt    <= pick_idx;
        op_q   <= op[pick_idx];
        pq_kvi <= kv_in[pick_idx];
      end
      if (state == ISSUE) kv_q <= pq_deq ? pq_kvo : '0;
      // Only the WAIT path carries a performed transaction; ISSUE->ACK is a reject.
      if (next_state == ACK && state != ACK) begin
        ack    <= NREQ'(1) << gnt;
        rsp_ok <= (state == WAIT);
        rsp_kv <= (state == WAIT) ? kv_q : '0;
        gnt_id <= gnt;
      end
      if (state == ACK) ptr <= (gnt == GW'(NREQ - 1)) ? '0 : gnt + GW'(1);
    end
  end

endmodule

// File: tb/tb_pq_client_arb.sv
// Scoreboard bench for pq_client_arb: directed stimulus, decoupled strobe/ack monitor.
module tb_pq_client_arb;
  import pq_client_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned GW   = $clog2(NREQ);

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, op, ack;
  kv_t  [NREQ-1:0] kv_in;
  logic            rsp_ok, pq_rst, pq_enq, pq_deq;
  kv_t             rsp_kv, pq_kvi, pq_kvo;
  logic [GW-1:0]   gnt_id;
  logic            pq_full, pq_busy, pq_empty;

  pq_client_arb #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .kv_in(kv_in),
    .ack(ack), .rsp_ok(rsp_ok), .rsp_kv(rsp_kv), .gnt_id(gnt_id),
    .pq_rst(pq_rst), .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
    .pq_full(pq_full), .pq_busy(pq_busy), .pq_empty(pq_empty), .pq_kvo(pq_kvo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int id; logic ok; kv_t kv; bit chk_kv;} ack_exp_t;
  typedef struct {int cyc; bit is_deq; kv_t kvi; bit chk_kvi;} stb_exp_t;

  ack_exp_t ack_q[$];
  stb_exp_t stb_q[$];
  int checks = 0;
  int passed = 0;
  int rem [NREQ];

  function automatic kv_t mk(input int k, input int v);
    kv_t r;
    r.key = KEY_W'(k);
    r.val = VAL_W'(v);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT strobes the queue or acks.
  always @(negedge clk) begin
    stb_exp_t se;
    ack_exp_t ae;
    int n;
    if (!rst) begin
      if (pq_enq || pq_deq) begin
        check("strobe_excl", 64'(pq_enq && pq_deq), 64'd0);
        n = stb_q.size();
        check("strobe_expected", 64'(n != 0), 64'd1);
        if (n != 0) begin
          se = stb_q.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(se.cyc));
          check("strobe_kind", 64'(pq_deq), 64'(se.is_deq));
          if (se.chk_kvi) check("pq_kvi", 64'(pq_kvi), 64'(se.kvi));
        end
      end
      if (ack != '0) begin
        check("ack_onehot", 64'($onehot(ack)), 64'd1);
        n = ack_q.size();
        check("ack_expected", 64'(n != 0), 64'd1);
        if (n != 0) begin
          ae = ack_q.pop_front();
          check("ack_cycle", 64'(cyc), 64'(ae.cyc));
          check("ack_vec", 64'(ack), 64'(NREQ'(1) << ae.id));
          check("gnt_id", 64'(gnt_id), 64'(ae.id));
          check("rsp_ok", 64'(rsp_ok), 64'(ae.ok));
          if (ae.chk_kv) check("rsp_kv", 64'(rsp_kv), 64'(ae.kv));
        end
      end
    end
  end

  // Requester model: drops req[i] in the cycle after its last expected ack.
  task automatic wait_acks(input int n);
    int got = 0;
    int budget = 200;
    logic [NREQ-1:0] a;
    while (got < n && budget > 0) begin
      @(negedge clk);
      a = ack;
      @(posedge clk); #1;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (a[i]) begin
          got++;
          rem[i]--;
          if (rem[i] <= 0) req[i] = 1'b0;
        end
      end
      budget--;
    end
    check("ack_count", 64'(got), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; req = '0; op = '0; kv_in = '0;
    pq_full = 1'b0; pq_busy = 1'b0; pq_empty = 1'b0; pq_kvo = '0;
    for (int i = 0; i < int'(NREQ); i++) rem[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_enq", 64'(pq_enq), 64'd0);
    check("rst_deq", 64'(pq_deq), 64'd0);
    check("rst_rsp_ok", 64'(rsp_ok), 64'd0);
    check("rst_rsp_kv", 64'(rsp_kv), 64'd0);
    check("rst_gnt_id", 64'(gnt_id), 64'd0);
    check("rst_pq_kvi", 64'(pq_kvi), 64'd0);
    check("rst_pq_rst", 64'(pq_rst), 64'd1);
    rst = 1'b0;
    #1 check("pq_rst_release", 64'(pq_rst), 64'd0);

    // Single enqueue from requester 2.
    @(posedge clk); #1; t0 = cyc;
    kv_in[2] = mk(5, 'hA); op[2] = OP_ENQ; req[2] = 1'b1; rem[2] = 1;
    stb_q.push_back('{t0 + 1, 1'b0, mk(5, 'hA), 1'b1});
    ack_q.push_back('{t0 + 3, 2, 1'b1, mk(0, 0), 1'b0});
    wait_acks(1);

    // Dequeue on empty: rejected, no strobe.
    @(posedge clk); #1; t0 = cyc;
    pq_empty = 1'b1; op[1] = OP_DEQ; req[1] = 1'b1; rem[1] = 1;
    ack_q.push_back('{t0 + 2, 1, 1'b0, mk(0, 0), 1'b1});
    wait_acks(1);
    pq_empty = 1'b0; op[1] = OP_ENQ;

    // Dequeue with the queue busy for four cycles starting at the strobe.
    @(posedge clk); #1; t0 = cyc;
    pq_kvo = mk(3, 'h77); op[0] = OP_DEQ; req[0] = 1'b1; rem[0] = 1;
    stb_q.push_back('{t0 + 1, 1'b1, mk(0, 0), 1'b0});
    ack_q.push_back('{t0 + 6, 0, 1'b1, mk(3, 'h77), 1'b1});
    fork
      begin
        @(posedge clk); #1; pq_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1 pq_busy = 1'b0;
      end
    join_none
    wait_acks(1);
    op[0] = OP_ENQ;

    // Enqueue on full is rejected; pointer still advances past requester 0.
    @(posedge clk); #1; t0 = cyc;
    pq_full = 1'b1; kv_in[0] = mk(1, 1); req[0] = 1'b1; rem[0] = 1;
    ack_q.push_back('{t0 + 2, 0, 1'b0, mk(0, 0), 1'b1});
    wait_acks(1);
    pq_full = 1'b0;
    @(posedge clk); #1; t0 = cyc;
    kv_in[0] = mk('h10, 'h20); kv_in[1] = mk('h11, 'h21);
    req[0] = 1'b1; req[1] = 1'b1; rem[0] = 1; rem[1] = 1;
    stb_q.push_back('{t0 + 1, 1'b0, mk('h11, 'h21), 1'b1});
    stb_q.push_back('{t0 + 5, 1'b0, mk('h10, 'h20), 1'b1});
    ack_q.push_back('{t0 + 3, 1, 1'b1, mk(0, 0), 1'b0});
    ack_q.push_back('{t0 + 7, 0, 1'b1, mk(0, 0), 1'b0});
    wait_acks(2);

    // Reset while stuck in WAIT abandons the transaction silently.
    @(posedge clk); #1; t0 = cyc;
    kv_in[2] = mk(9, 9); req[2] = 1'b1;
    stb_q.push_back('{t0 + 1, 1'b0, mk(9, 9), 1'b1});
    @(posedge clk); #1 pq_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_ack", 64'(ack), 64'd0);
    check("midrst_enq", 64'(pq_enq), 64'd0);
    check("midrst_deq", 64'(pq_deq), 64'd0);
    check("midrst_pq_rst", 64'(pq_rst), 64'd1);
    req = '0; pq_busy = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_stb_q", 64'(stb_q.size()), 64'd0);

    // All four request continuously: order 0,1,2,3,0 from a freshly reset pointer.
    @(posedge clk); #1; t0 = cyc;
    for (int i = 0; i < int'(NREQ); i++) kv_in[i] = mk('h40 + i, 'h50 + i);
    op = '0; req = '1;
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    for (int k = 0; k < 5; k++) begin
      stb_q.push_back('{t0 + 1 + 4 * k, 1'b0, mk('h40 + (k % 4), 'h50 + (k % 4)), 1'b1});
      ack_q.push_back('{t0 + 3 + 4 * k, k % 4, 1'b1, mk(0, 0), 1'b0});
    end
    wait_acks(5);

    repeat (5) @(posedge clk);
    check("end_ack_q", 64'(ack_q.size()), 64'd0);
    check("end_stb_q", 64'(stb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
